// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its buttons, BCD datapath and display.
// The controller takes the master modport; the datapath/display side takes the slave modport.
interface stopwatch_ctrl_if;
   logic       btn_start_raw;
   logic       btn_lap_raw;
   logic [3:0] cnt_d0;
   logic [3:0] cnt_d1;
   logic [3:0] cnt_d2;
   logic [3:0] cnt_d3;
   logic       run;
   logic       clear;
   logic [3:0] disp_d0;
   logic [3:0] disp_d1;
   logic [3:0] disp_d2;
   logic [3:0] disp_d3;
   logic       lap_active;
   logic [1:0] state;

   modport master (
      input  btn_start_raw, btn_lap_raw,
      input  cnt_d0, cnt_d1, cnt_d2, cnt_d3,
      output run, clear,
      output disp_d0, disp_d1, disp_d2, disp_d3,
      output lap_active, state
   );

   modport slave (
      output btn_start_raw, btn_lap_raw,
      output cnt_d0, cnt_d1, cnt_d2, cnt_d3,
      input  run, clear,
      input  disp_d0, disp_d1, disp_d2, disp_d3,
      input  lap_active, state
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounces START/STOP and LAP/RESET, sequences idle/run/pause/lap,
// and drives the datapath enable/clear plus the live-or-frozen display digits.
module stopwatch_ctrl #(
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter int   CNT_W           = 20,
   parameter logic STOP_AT_MAX     = 1'b1
) (
   input logic              clk,
   input logic              reset,
   stopwatch_ctrl_if.master sw
);

   localparam logic [1:0]       ST_IDLE   = 2'd0;
   localparam logic [1:0]       ST_RUN    = 2'd1;
   localparam logic [1:0]       ST_PAUSED = 2'd2;
   localparam logic [1:0]       ST_LAP    = 2'd3;
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DB_ONE    = CNT_W'(1);

   // bit 0 = START/STOP, bit 1 = LAP/RESET
   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       deb_q, deb_d, deb_dly_q, press_s;
   logic [CNT_W-1:0] db_cnt_q [2];
   logic [CNT_W-1:0] db_cnt_d [2];
   logic [1:0]       state_q, state_d;
   logic             clear_q, clear_d;
   logic [15:0]      lap_q, cnt_s;
   logic             lap_we_s, at_max_s, max_stop_s, sp_s, lp_s;

   assign cnt_s      = {sw.cnt_d3, sw.cnt_d2, sw.cnt_d1, sw.cnt_d0};
   assign at_max_s   = (cnt_s == 16'h9599);
   assign max_stop_s = STOP_AT_MAX & at_max_s;
   assign press_s    = deb_q & ~deb_dly_q;
   assign sp_s       = press_s[0];
   assign lp_s       = press_s[1];

   // Debounce: accept the synchronised level only after it has differed for DEBOUNCE_CYCLES cycles
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         deb_d[b]    = deb_q[b];
         db_cnt_d[b] = '0;
         if (sync2_q[b] != deb_q[b]) begin
            if (db_cnt_q[b] == DB_LAST) begin
               deb_d[b]    = sync2_q[b];
               db_cnt_d[b] = '0;
            end else begin
               db_cnt_d[b] = db_cnt_q[b] + DB_ONE;
            end
         end else begin
            db_cnt_d[b] = '0;
         end
      end
   end

   // Next-state logic; a start press outranks a lap press, and hitting 9:59.9 forces a pause
   always_comb begin
      state_d  = state_q;
      clear_d  = 1'b0;
      lap_we_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sp_s) begin
               state_d = ST_RUN;
            end else if (lp_s) begin
               state_d = ST_IDLE;
               clear_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (sp_s || max_stop_s) begin
               state_d = ST_PAUSED;
            end else if (lp_s) begin
               state_d  = ST_LAP;
               lap_we_s = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_LAP: begin
            if (sp_s || max_stop_s) begin
               state_d = ST_PAUSED;
            end else if (lp_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_LAP;
            end
         end
         ST_PAUSED: begin
            if (sp_s) begin
               state_d = ST_RUN;
            end else if (lp_s) begin
               state_d = ST_IDLE;
               clear_d = 1'b1;
            end else begin
               state_d = ST_PAUSED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, button conditioning and lap latch registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= 2'b00;
         sync2_q     <= 2'b00;
         deb_q       <= 2'b00;
         deb_dly_q   <= 2'b00;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
         state_q     <= ST_IDLE;
         clear_q     <= 1'b0;
         lap_q       <= 16'h0000;
      end else begin
         sync1_q     <= {sw.btn_lap_raw, sw.btn_start_raw};
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         deb_dly_q   <= deb_q;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
         state_q     <= state_d;
         clear_q     <= clear_d;
         if (lap_we_s) begin
            lap_q <= cnt_s;
         end else begin
            lap_q <= lap_q;
         end
      end
   end

   // run is combinational so the datapath stops on the very cycle it shows 9:59.9
   assign sw.run        = ((state_q == ST_RUN) || (state_q == ST_LAP)) && !max_stop_s;
   assign sw.clear      = clear_q;
   assign sw.state      = state_q;
   assign sw.lap_active = (state_q == ST_LAP);
   assign sw.disp_d0    = (state_q == ST_LAP) ? lap_q[3:0]   : sw.cnt_d0;
   assign sw.disp_d1    = (state_q == ST_LAP) ? lap_q[7:4]   : sw.cnt_d1;
   assign sw.disp_d2    = (state_q == ST_LAP) ? lap_q[11:8]  : sw.cnt_d2;
   assign sw.disp_d3    = (state_q == ST_LAP) ? lap_q[15:12] : sw.cnt_d3;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (stop-at-max and wrapping), each fed by its own
// bench-side tenths counter, checked every cycle against a behavioural model plus literal pins.
module tb_stopwatch_ctrl;

   localparam int DB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic btn_start;
   logic btn_lap;
   logic preset_en;
   int   preset_val;

   // Model: raw-sample history per button, debounced level, pending press, and per-instance FSM
   logic [15:0] hist [2]  = '{16'h0000, 16'h0000};
   logic        deb_m [2] = '{1'b0, 1'b0};
   logic        pend_m [2] = '{1'b0, 1'b0};
   logic [1:0]  ms [2]    = '{2'd0, 2'd0};
   logic        mclr [2]  = '{1'b0, 1'b0};
   logic [15:0] mlap [2]  = '{16'h0000, 16'h0000};
   int          t_m [2]   = '{0, 0};
   logic        model_ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   int          pin_sel [16];
   logic [15:0] pin_exp [16];
   int          pin_n = 0;
   int          pin_seq = 0;
   int          pin_seen = 0;
   bit          pin_fired = 1'b0;

   stopwatch_ctrl_if if_a ();
   stopwatch_ctrl_if if_b ();

   function automatic logic [15:0] bcd(input int v);
      return {4'(v / 600), 4'((v / 100) % 6), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Instance 0 stops at 9:59.9 (5999 tenths); instance 1 wraps
   function automatic bit model_run(input int i);
      return ((ms[i] == 2'd1) || (ms[i] == 2'd3)) && !((i == 0) && (t_m[i] == 5999));
   endfunction

   function automatic logic [15:0] model_disp(input int i);
      return (ms[i] == 2'd3) ? mlap[i] : bcd(t_m[i]);
   endfunction

   assign if_a.btn_start_raw = btn_start;
   assign if_a.btn_lap_raw   = btn_lap;
   assign if_b.btn_start_raw = btn_start;
   assign if_b.btn_lap_raw   = btn_lap;
   assign {if_a.cnt_d3, if_a.cnt_d2, if_a.cnt_d1, if_a.cnt_d0} = bcd(t_m[0]);
   assign {if_b.cnt_d3, if_b.cnt_d2, if_b.cnt_d1, if_b.cnt_d0} = bcd(t_m[1]);

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(20), .STOP_AT_MAX(1'b1)) dut_a (
      .clk(clk), .reset(reset), .sw(if_a.master));
   stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(20), .STOP_AT_MAX(1'b0)) dut_b (
      .clk(clk), .reset(reset), .sw(if_b.master));

   // Behavioural model and bench datapath, advanced on each rising edge
   always @(posedge clk) begin : model
      bit flip;
      bit sp;
      bit lp;
      bit stp;
      sp = pend_m[0];
      lp = pend_m[1];
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            hist[b]   <= 16'h0000;
            deb_m[b]  <= 1'b0;
            pend_m[b] <= 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            ms[i]   <= 2'd0;
            mclr[i] <= 1'b0;
            mlap[i] <= 16'h0000;
         end
         model_ready <= 1'b1;
      end else begin
         for (int b = 0; b < 2; b++) begin
            // synchronised level two samples back must have disagreed for DB straight cycles
            flip = 1'b1;
            for (int j = 1; j <= DB; j++) begin
               if (hist[b][j] == deb_m[b]) flip = 1'b0;
            end
            hist[b]   <= {hist[b][14:0], (b == 0) ? btn_start : btn_lap};
            if (flip) deb_m[b] <= ~deb_m[b];
            pend_m[b] <= flip && !deb_m[b];
         end
         for (int i = 0; i < 2; i++) begin
            stp = (i == 0) && (t_m[i] == 5999);
            mclr[i] <= 1'b0;
            case (ms[i])
               2'd0: if (sp) ms[i] <= 2'd1; else if (lp) mclr[i] <= 1'b1;
               2'd1: if (sp || stp) ms[i] <= 2'd2;
                     else if (lp) begin ms[i] <= 2'd3; mlap[i] <= bcd(t_m[i]); end
               2'd3: if (sp || stp) ms[i] <= 2'd2; else if (lp) ms[i] <= 2'd1;
               default: if (sp) ms[i] <= 2'd1;
                        else if (lp) begin ms[i] <= 2'd0; mclr[i] <= 1'b1; end
            endcase
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (preset_en)      t_m[i] <= preset_val;
         else if (mclr[i])   t_m[i] <= 0;
         else if (model_run(i)) t_m[i] <= (t_m[i] + 1) % 6000;
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Compare process: model check every cycle, then any pinned literal expectations
   always @(negedge clk) begin : compare
      logic [15:0] act;
      if (model_ready) begin
         chk("state_a", 16'(if_a.state), 16'(ms[0]));
         chk("run_a", 16'(if_a.run), 16'(model_run(0)));
         chk("clear_a", 16'(if_a.clear), 16'(mclr[0]));
         chk("lap_a", 16'(if_a.lap_active), 16'(ms[0] == 2'd3));
         chk("disp_a", {if_a.disp_d3, if_a.disp_d2, if_a.disp_d1, if_a.disp_d0}, model_disp(0));
         chk("state_b", 16'(if_b.state), 16'(ms[1]));
         chk("run_b", 16'(if_b.run), 16'(model_run(1)));
         chk("clear_b", 16'(if_b.clear), 16'(mclr[1]));
         chk("lap_b", 16'(if_b.lap_active), 16'(ms[1] == 2'd3));
         chk("disp_b", {if_b.disp_d3, if_b.disp_d2, if_b.disp_d1, if_b.disp_d0}, model_disp(1));
      end
      if (pin_seq != pin_seen) begin
         for (int k = 0; k < pin_n; k++) begin
            case (pin_sel[k])
               0: act = 16'(if_a.state);
               1: act = 16'(if_a.run);
               2: act = 16'(if_a.clear);
               3: act = 16'(if_a.lap_active);
               4: act = {if_a.disp_d3, if_a.disp_d2, if_a.disp_d1, if_a.disp_d0};
               5: act = 16'(if_b.state);
               6: act = 16'(if_b.run);
               default: act = {if_b.disp_d3, if_b.disp_d2, if_b.disp_d1, if_b.disp_d0};
            endcase
            chk($sformatf("pin%0d_sel%0d", pin_seq, pin_sel[k]), act, pin_exp[k]);
         end
         pin_seen = pin_seq;
      end
   end

   localparam int ST_A = 0, RUN_A = 1, CLR_A = 2, LAP_A = 3, DISP_A = 4;
   localparam int ST_B = 5, RUN_B = 6, DISP_B = 7;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pin(input int sel, input logic [15:0] exp);
      if (pin_fired) begin
         pin_n = 0;
         pin_fired = 1'b0;
      end
      pin_sel[pin_n] = sel;
      pin_exp[pin_n] = exp;
      pin_n++;
   endtask

   task automatic go();
      pin_seq++;
      pin_fired = 1'b1;
   endtask

   // Buttons rise before edge k; the FSM acts at edge k+6, preset lands on the edge just before
   task automatic press(input bit s, input bit l, input bit pre, input int val);
      btn_start = s;
      btn_lap   = l;
      cyc(5);
      preset_en  = pre;
      preset_val = val;
      cyc(1);
      preset_en = 1'b0;
      cyc(1);
   endtask

   task automatic rel();
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      cyc(8);
   endtask

   initial begin
      reset = 1'b1;
      btn_start = 1'b0;
      btn_lap = 1'b0;
      preset_en = 1'b0;
      preset_val = 0;
      cyc(2);
      pin(ST_A, 16'd0); pin(RUN_A, 16'd0); pin(CLR_A, 16'd0); pin(LAP_A, 16'd0);
      pin(DISP_A, 16'h0000); go();
      reset = 1'b0;

      // debounce latency and start
      btn_start = 1'b1;
      cyc(5); pin(ST_A, 16'd0); go();
      cyc(1); pin(ST_A, 16'd0); go();
      cyc(1); pin(ST_A, 16'd1); pin(RUN_A, 16'd1); go();
      btn_start = 1'b0;
      cyc(8);
      btn_start = 1'b1;
      cyc(3);
      btn_start = 1'b0;
      cyc(10); pin(ST_A, 16'd1); go();

      // pause then reset to idle with one clear pulse
      press(1'b1, 1'b0, 1'b0, 0); pin(ST_A, 16'd2); pin(RUN_A, 16'd0); go(); rel();
      press(1'b0, 1'b1, 1'b0, 0); pin(ST_A, 16'd0); pin(CLR_A, 16'd1); pin(RUN_A, 16'd0); go();
      cyc(1); pin(CLR_A, 16'd0); pin(DISP_A, 16'h0000); go();
      rel();

      // lap freeze at 0:12.3
      press(1'b1, 1'b0, 1'b0, 0); pin(ST_A, 16'd1); go(); rel();
      press(1'b0, 1'b1, 1'b1, 123);
      pin(ST_A, 16'd3); pin(LAP_A, 16'd1); pin(DISP_A, 16'h0123); pin(DISP_B, 16'h0123); go();
      rel(); pin(DISP_A, 16'h0123); pin(LAP_A, 16'd1); go();
      press(1'b0, 1'b1, 1'b0, 0); pin(ST_A, 16'd1); pin(LAP_A, 16'd0); go(); rel();

      // simultaneous presses: start wins, no capture
      press(1'b1, 1'b1, 1'b0, 0); pin(ST_A, 16'd2); pin(LAP_A, 16'd0); go(); rel();
      pin(ST_A, 16'd2); go();

      // run from 9:59.0 up to max: instance a stops, instance b wraps
      press(1'b1, 1'b0, 1'b1, 5990);
      btn_start = 1'b0;
      cyc(9);
      pin(RUN_A, 16'd0); pin(ST_A, 16'd1); pin(DISP_A, 16'h9599); pin(RUN_B, 16'd1); pin(ST_B, 16'd1); go();
      cyc(1);
      pin(ST_A, 16'd2); pin(DISP_A, 16'h9599); pin(ST_B, 16'd1); pin(RUN_B, 16'd1); pin(DISP_B, 16'h0000); go();
      cyc(2); pin(DISP_A, 16'h9599); pin(ST_A, 16'd2); go();
      cyc(6);

      // reach LAP, then reset while LAP/RESET is held
      press(1'b0, 1'b1, 1'b0, 0); rel();
      press(1'b1, 1'b0, 1'b0, 0); rel();
      press(1'b0, 1'b1, 1'b0, 0); pin(ST_A, 16'd3); go();
      cyc(2);
      reset = 1'b1;
      cyc(1);
      pin(ST_A, 16'd0); pin(RUN_A, 16'd0); pin(CLR_A, 16'd0); pin(LAP_A, 16'd0);
      pin(ST_B, 16'd0); pin(RUN_B, 16'd0); go();
      reset = 1'b0;
      cyc(6); pin(ST_A, 16'd0); pin(CLR_A, 16'd0); go();
      cyc(1); pin(ST_A, 16'd0); pin(CLR_A, 16'd1); go();
      cyc(1); pin(CLR_A, 16'd0); go();
      btn_lap = 1'b0;
      cyc(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the 4-digit BCD stopwatch datapath (d3 minutes 0-9, d2 tens of seconds 0-5, d1 seconds 0-9, d0 tenths 0-9).
- Debounces two raw push-buttons, START/STOP and LAP/RESET.
- Sequences the datapath through idle, run, pause and lap-freeze states.
- Drives the datapath count enable and clear, and muxes live or frozen digits to the display path.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clk cycles a synchronised button must differ from its debounced value before the change is accepted; must be >= 2.
CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1.
STOP_AT_MAX, 1, when 1, counting halts at 9:59.9 instead of wrapping.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
btn_start_raw  input  1  raw asynchronous START/STOP button, active-high
btn_lap_raw  input  1  raw asynchronous LAP/RESET button, active-high
cnt_d0..cnt_d3  input  4 each  live BCD digits from datapath
run  output  1  count enable to datapath
clear  output  1  one-cycle clear pulse to datapath
disp_d0..disp_d3  output  4 each  digits to display mux
lap_active  output  1  high while display is frozen
state  output  2  encoded FSM state: IDLE=0, RUNNING=1, PAUSED=2, LAP=3

Behaviour:
- Reset values (at the clk edge with reset high):
  - state=IDLE; run=0; clear=0; lap_active=0.
  - Lap latch = 0; synchronisers, debounced values and counters = 0.
  - disp_d* therefore follow cnt_d*.
- Per-button input conditioning:
  - 2-flop synchroniser: raw -> s1 -> s2.
  - Debounce counter: increments each cycle s2 != deb; cleared whenever s2 == deb.
  - When the counter is DEBOUNCE_CYCLES-1 and s2 != deb: deb <= s2 and counter <= 0.
  - press = deb & ~deb_q, where deb_q is deb delayed one cycle. press is a one-cycle pulse on a debounced rising edge only; release generates nothing.
- Latency: raw rises before edge k and is held. deb flips at edge k+DEBOUNCE_CYCLES+1. press is high in the following cycle. The FSM acts at edge k+DEBOUNCE_CYCLES+2.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never sets deb.
- FSM transitions (sp = start press, lp = lap press):
  - IDLE: sp -> RUNNING. lp -> IDLE with clear=1 for one cycle.
  - RUNNING: sp -> PAUSED. lp -> LAP, capturing cnt_d* into the lap latch at the same edge.
  - LAP: sp -> PAUSED, freeze released. lp -> RUNNING, freeze released.
  - PAUSED: sp -> RUNNING. lp -> IDLE with clear=1 for one cycle.
- Simultaneous sp and lp in the same cycle: sp wins and lp is discarded. It is not queued.
- Outputs:
  - run = (state==RUNNING || state==LAP) && !(STOP_AT_MAX && at_max).
  - at_max = (cnt_d3==9 && cnt_d2==5 && cnt_d1==9 && cnt_d0==9).
  - run is combinational from registered state and cnt_d*, so the datapath never increments past max.
- Max reached: with STOP_AT_MAX=1 and at_max in RUNNING or LAP, the next edge enters PAUSED and the freeze is released. An sp in that same cycle also yields PAUSED.
- clear is registered; it is high exactly in the cycle after the edge that takes the transition to IDLE. run is 0 in that cycle.
- Display: lap_active = (state==LAP). disp_d* = lap_active ? lap latch : cnt_d*.
- Lap latch: written only on the RUNNING->LAP transition; holds its value otherwise.
- Reset mid-operation (any state, button mid-debounce): everything returns to reset values at that edge. A button held through reset is accepted as a press only after the full debounce from deb=0.
- STOP_AT_MAX=0: at_max is ignored; the datapath wraps 9:59.9 -> 0:00.0 and the FSM stays in RUNNING/LAP.

Test Plan:
1. Debounce and start. DEBOUNCE_CYCLES=4. Reset, then hold btn_start_raw high from edge k. state==RUNNING and run==1 after edge k+6. A 3-cycle pulse on btn_start_raw causes no change.
2. Full cycle. From IDLE: sp -> RUNNING; sp -> PAUSED (run=0, cnt holds); lp -> IDLE. clear is high exactly one cycle and state==0.
3. Lap freeze. RUNNING with cnt=0:12.3, press LAP: disp==0:12.3 and lap_active=1 while cnt keeps advancing. LAP again: disp tracks cnt and state==RUNNING.
4. Simultaneous presses. sp and lp in the same cycle while RUNNING -> PAUSED; no lap capture, lap_active stays 0.
5. Max stop. STOP_AT_MAX=1; datapath reaches 9:59.9 while RUNNING -> run drops that cycle and state==PAUSED next edge; cnt stays 9:59.9. With STOP_AT_MAX=0 -> cnt wraps to 0:00.0 and run stays 1.
6. Reset mid-LAP with btn_lap_raw held. All outputs return to reset values, disp==cnt. A LAP press is recognised 6 cycles after reset deasserts, giving IDLE with a clear pulse.
